// File: rtl/cellrv32_cpu_rf_scoreboard.sv
// cellrv32_cpu_rf_scoreboard: hazard scoreboard in front of the data register file.
// Tracks in-flight long-latency rd writes in an in-order FIFO and stalls RAW/WAW issue.
//
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   flush_i                drop all pending writes at the next edge
//   issue_valid_i          an instruction is presented for issue
//   issue_ll_i             presented instruction is a long-latency writer of rd
//   issue_rd_i             destination register
//   issue_rs1/2/3_i        source registers
//   issue_use_i            bit i set = rs(i+1) is actually read
//   stall_o                issue blocked this cycle (combinational)
//   cmpl_valid_i           oldest long-latency op completes this cycle
//   cmpl_rd_o, cmpl_we_o   register-file write address / enable for the completion
//   busy_o                 per-register pending-write bits
//   pend_cnt_o, empty_o    FIFO occupancy / occupancy == 0
//   err_o                  sticky: completion arrived while the FIFO was empty
module cellrv32_cpu_rf_scoreboard #(
    parameter int CPU_EXTENSION_RISCV_E = 0,
    parameter int PEND_DEPTH            = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    input  logic                          issue_ll_i,
    input  logic [4:0]                    issue_rd_i,
    input  logic [4:0]                    issue_rs1_i,
    input  logic [4:0]                    issue_rs2_i,
    input  logic [4:0]                    issue_rs3_i,
    input  logic [2:0]                    issue_use_i,
    output logic                          stall_o,
    input  logic                          cmpl_valid_i,
    output logic [4:0]                    cmpl_rd_o,
    output logic                          cmpl_we_o,
    output logic [31:0]                   busy_o,
    output logic [$clog2(PEND_DEPTH):0]   pend_cnt_o,
    output logic                          empty_o,
    output logic                          err_o
);

    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = PW + 1;

    // RV32E folds the register space onto 16 entries by dropping bit 4.
    function automatic logic [4:0] reg_idx(input logic [4:0] a);
        if (CPU_EXTENSION_RISCV_E != 0) begin
            return {1'b0, a[3:0]};
        end
        return a;
    endfunction

    logic [4:0]    fifo_q [PEND_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   busy_q;
    logic          err_q;

    logic [4:0]    rd_n;
    logic [4:0]    rs1_n;
    logic [4:0]    rs2_n;
    logic [4:0]    rs3_n;
    logic [4:0]    head_rd;
    logic          full;
    logic          empty;
    logic          rs_haz;
    logic          hazard;
    logic          push;
    logic          pop;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;
    logic [31:0]   busy_d;
    logic [CW-1:0] cnt_d;

    always_comb begin
        rd_n    = reg_idx(issue_rd_i);
        rs1_n   = reg_idx(issue_rs1_i);
        rs2_n   = reg_idx(issue_rs2_i);
        rs3_n   = reg_idx(issue_rs3_i);
        head_rd = fifo_q[rptr_q];

        full  = (cnt_q == CW'(PEND_DEPTH));
        empty = (cnt_q == '0);

        // busy_q[0] is never set, so x0 sources/destinations never hazard.
        // Only registered busy bits are consulted: a completion releases a
        // dependent instruction one cycle later, never in the same cycle.
        rs_haz = (issue_use_i[0] & busy_q[rs1_n])
               | (issue_use_i[1] & busy_q[rs2_n])
               | (issue_use_i[2] & busy_q[rs3_n]);
        hazard = rs_haz | (issue_ll_i & (busy_q[rd_n] | full));

        stall_o = issue_valid_i & hazard;
        push    = issue_valid_i & issue_ll_i & ~hazard & ~flush_i;
        pop     = cmpl_valid_i & ~empty & ~flush_i;

        set_vec = '0;
        if (push && (rd_n != 5'd0)) begin
            set_vec = 32'd1 << rd_n;
        end
        clr_vec = '0;
        if (pop) begin
            clr_vec = 32'd1 << head_rd;
        end

        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        if (CPU_EXTENSION_RISCV_E != 0) begin
            busy_d[31:16] = '0;
        end

        cnt_d = cnt_q + CW'(push) - CW'(pop);

        cmpl_rd_o  = head_rd;
        cmpl_we_o  = cmpl_valid_i & ~empty & (head_rd != 5'd0);
        busy_o     = busy_q;
        pend_cnt_o = cnt_q;
        empty_o    = empty;
        err_o      = err_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            // err_o is independent of flush: a stray completion is always recorded.
            if (cmpl_valid_i && empty) begin
                err_q <= 1'b1;
            end
            if (flush_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                busy_q <= '0;
            end else begin
                // x0 is still pushed so completion order stays aligned.
                if (push) begin
                    fifo_q[wptr_q] <= rd_n;
                    wptr_q         <= wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                cnt_q  <= cnt_d;
                busy_q <= busy_d;
            end
        end
    end

endmodule

// File: tb/tb_cellrv32_cpu_rf_scoreboard.sv
// Directed bench for cellrv32_cpu_rf_scoreboard (RV32I and RV32E instances).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_cellrv32_cpu_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        iv = 1'b0;
    logic        ll = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rs3 = '0;
    logic [2:0]  use_v = '0;
    logic        cv = 1'b0;

    logic        stall, we, empty, err;
    logic [4:0]  crd;
    logic [31:0] busy;
    logic [2:0]  cnt;

    logic        e_stall, e_we, e_empty, e_err;
    logic [4:0]  e_crd;
    logic [31:0] e_busy;
    logic [2:0]  e_cnt;

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    cellrv32_cpu_rf_scoreboard #(
        .CPU_EXTENSION_RISCV_E(0),
        .PEND_DEPTH(4)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .issue_valid_i(iv), .issue_ll_i(ll), .issue_rd_i(rd),
        .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rs3_i(rs3),
        .issue_use_i(use_v), .stall_o(stall), .cmpl_valid_i(cv),
        .cmpl_rd_o(crd), .cmpl_we_o(we), .busy_o(busy),
        .pend_cnt_o(cnt), .empty_o(empty), .err_o(err)
    );

    cellrv32_cpu_rf_scoreboard #(
        .CPU_EXTENSION_RISCV_E(1),
        .PEND_DEPTH(4)
    ) u_dut_e (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .issue_valid_i(iv), .issue_ll_i(ll), .issue_rd_i(rd),
        .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rs3_i(rs3),
        .issue_use_i(use_v), .stall_o(e_stall), .cmpl_valid_i(cv),
        .cmpl_rd_o(e_crd), .cmpl_we_o(e_we), .busy_o(e_busy),
        .pend_cnt_o(e_cnt), .empty_o(e_empty), .err_o(e_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic l, input logic [4:0] d,
                       input logic [4:0] s1, input logic [2:0] u,
                       input logic c, input logic f);
        @(negedge clk);
        iv = v; ll = l; rd = d; rs1 = s1; use_v = u; cv = c; flush = f;
        #1;
    endtask

    task automatic idle(input logic c);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 3'b000, c, 1'b0);
    endtask

    initial begin
        // reset state
        idle(0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_crd", 32'(crd), 0);
        chk("rst_stall", 32'(stall), 0);
        rstn = 1'b1;

        // T1 simple RAW
        cyc(1, 1, 5, 0, 3'b000, 0, 0);
        chk("t1_issue_stall", 32'(stall), 0);
        cyc(1, 0, 0, 5, 3'b001, 0, 0);
        chk("t1_raw_stall", 32'(stall), 1);
        chk("t1_busy", busy, 32'h20);
        chk("t1_cnt", 32'(cnt), 1);
        cyc(1, 0, 0, 5, 3'b001, 1, 0);
        chk("t1_cmpl_stall", 32'(stall), 1);
        chk("t1_cmpl_rd", 32'(crd), 5);
        chk("t1_cmpl_we", 32'(we), 1);
        cyc(1, 0, 0, 5, 3'b001, 0, 0);
        chk("t1_release", 32'(stall), 0);
        chk("t1_busy_clr", busy, 0);
        chk("t1_empty", 32'(empty), 1);

        // T2 fill to depth, 5th stalls until one retires
        for (int r = 1; r <= 4; r++) begin
            cyc(1, 1, 5'(r), 0, 3'b000, 0, 0);
            chk("t2_fill_stall", 32'(stall), 0);
        end
        cyc(1, 1, 6, 0, 3'b000, 1, 0);
        chk("t2_cnt_full", 32'(cnt), 4);
        chk("t2_full_stall", 32'(stall), 1);
        chk("t2_head1", 32'(crd), 1);
        chk("t2_we1", 32'(we), 1);
        cyc(1, 1, 6, 0, 3'b000, 0, 0);
        chk("t2_accept", 32'(stall), 0);
        chk("t2_cnt3", 32'(cnt), 3);
        chk("t2_busy3", busy, 32'h1C);
        idle(1);
        chk("t2_cnt4", 32'(cnt), 4);
        chk("t2_busy4", busy, 32'h5C);
        chk("t2_head2", 32'(crd), 2);
        idle(1);
        chk("t2_head3", 32'(crd), 3);
        idle(1);
        chk("t2_head4", 32'(crd), 4);
        idle(1);
        chk("t2_head6_wrap", 32'(crd), 6);
        idle(0);
        chk("t2_empty", 32'(empty), 1);
        chk("t2_busy0", busy, 0);

        // T3 x0 keeps completion order
        cyc(1, 1, 0, 0, 3'b000, 0, 0);
        chk("t3_x0_stall", 32'(stall), 0);
        cyc(1, 1, 7, 0, 3'b000, 0, 0);
        chk("t3_x0_cnt", 32'(cnt), 1);
        chk("t3_x0_busy", busy, 0);
        idle(1);
        chk("t3_cnt2", 32'(cnt), 2);
        chk("t3_busy7", busy, 32'h80);
        chk("t3_head0", 32'(crd), 0);
        chk("t3_we0", 32'(we), 0);
        idle(1);
        chk("t3_busy_kept", busy, 32'h80);
        chk("t3_cnt1", 32'(cnt), 1);
        chk("t3_head7", 32'(crd), 7);
        chk("t3_we7", 32'(we), 1);
        idle(0);
        chk("t3_empty", 32'(empty), 1);

        // T4 same-cycle push and pop
        cyc(1, 1, 3, 0, 3'b000, 0, 0);
        cyc(1, 1, 9, 0, 3'b000, 1, 0);
        chk("t4_stall", 32'(stall), 0);
        chk("t4_head3", 32'(crd), 3);
        chk("t4_we", 32'(we), 1);
        idle(0);
        chk("t4_cnt", 32'(cnt), 1);
        chk("t4_busy", busy, 32'h200);
        idle(1);
        chk("t4_head9", 32'(crd), 9);
        idle(0);
        chk("t4_empty", 32'(empty), 1);

        // T6 flush, stray completion, async reset
        cyc(1, 1, 10, 0, 3'b000, 0, 0);
        cyc(1, 1, 11, 0, 3'b000, 0, 0);
        cyc(1, 1, 12, 0, 3'b000, 0, 0);
        cyc(0, 0, 0, 0, 3'b000, 0, 1);
        chk("t6_cnt3", 32'(cnt), 3);
        chk("t6_busy3", busy, 32'h1C00);
        idle(0);
        chk("t6_flush_busy", busy, 0);
        chk("t6_flush_empty", 32'(empty), 1);
        chk("t6_flush_cnt", 32'(cnt), 0);
        chk("t6_err_pre", 32'(err), 0);
        idle(1);
        chk("t6_stray_we", 32'(we), 0);
        idle(0);
        chk("t6_err", 32'(err), 1);
        chk("t6_err_empty", 32'(empty), 1);
        cyc(1, 1, 13, 0, 3'b000, 0, 0);
        idle(0);
        chk("t6_busy13", busy, 32'h2000);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_err", 32'(err), 0);
        chk("t6_arst_cnt", 32'(cnt), 0);
        chk("t6_arst_empty", 32'(empty), 1);
        idle(0);
        rstn = 1'b1;

        // T5 WAW under RV32E
        cyc(1, 1, 18, 0, 3'b000, 0, 0);
        chk("t5_e_stall0", 32'(e_stall), 0);
        chk("t5_e_busy0", e_busy, 0);
        cyc(1, 1, 2, 0, 3'b000, 0, 0);
        chk("t5_e_waw", 32'(e_stall), 1);
        chk("t5_e_busy2", e_busy, 32'h4);
        chk("t5_e_hi", e_busy & 32'hFFFF0000, 0);
        chk("t5_i_nowaw", 32'(stall), 0);
        cyc(1, 1, 2, 0, 3'b000, 1, 0);
        chk("t5_e_cmpl_stall", 32'(e_stall), 1);
        chk("t5_e_head", 32'(e_crd), 2);
        chk("t5_e_we", 32'(e_we), 1);
        cyc(1, 1, 2, 0, 3'b000, 0, 0);
        chk("t5_e_release", 32'(e_stall), 0);
        chk("t5_e_busy_clr", e_busy, 0);
        idle(0);
        chk("t5_e_busy_re", e_busy, 32'h4);
        chk("t5_e_cnt", 32'(e_cnt), 1);
        chk("t5_e_hi2", e_busy & 32'hFFFF0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
